// File: rtl/tdc_link_align_ctrl.sv
// tdc_link_align_ctrl
//   Word-alignment and link-supervision controller for the TDC 8b10b
//   receive path. Watches the decoder's per-word outputs, issues bitslip
//   pulses to the deserializer until K28.5 commas decode, confirms lock
//   after LOCK_CNT consecutive good commas, and drops lock (restarting
//   from a decoder soft reset) when too many errors land in one window.
//
// Ports
//   i_Clk, i_ARst_L    clock, asynchronous active-low reset
//   i_word_valid       decoder word valid this cycle
//   i_Dout/i_Kout      decoded byte and K flag
//   i_DErr/i_DpErr     code error / disparity error
//   o_bitslip          one-cycle bitslip pulse
//   o_dec_soft_reset   decoder soft reset
//   o_force_disparity  decoder ForceDisparity
//   o_disparity        forced disparity value (1 = negative)
//   o_locked           link locked
//   o_state            FSM state (0 RST_DEC,1 SEARCH,2 SLIP,3 CONFIRM,4 LOCKED)
//   o_slip_count       bitslips since last lock, modulo 10
//   o_lock_loss_cnt    lock losses, saturating at 255
module tdc_link_align_ctrl #(
  parameter logic [7:0] COMMA        = 8'hBC,
  parameter int         SEARCH_WORDS = 20,
  parameter int         SLIP_WAIT    = 16,
  parameter int         LOCK_CNT     = 8,
  parameter int         ERR_WINDOW   = 64,
  parameter int         ERR_THRESH   = 4,
  parameter int         RST_CYC      = 2
) (
  input  logic       i_Clk,
  input  logic       i_ARst_L,
  input  logic       i_word_valid,
  input  logic [7:0] i_Dout,
  input  logic       i_Kout,
  input  logic       i_DErr,
  input  logic       i_DpErr,
  output logic       o_bitslip,
  output logic       o_dec_soft_reset,
  output logic       o_force_disparity,
  output logic       o_disparity,
  output logic       o_locked,
  output logic [2:0] o_state,
  output logic [3:0] o_slip_count,
  output logic [7:0] o_lock_loss_cnt
);

  typedef enum logic [2:0] {
    ST_RST_DEC = 3'd0,
    ST_SEARCH  = 3'd1,
    ST_SLIP    = 3'd2,
    ST_CONFIRM = 3'd3,
    ST_LOCKED  = 3'd4
  } state_t;

  localparam int RC_W = $clog2(RST_CYC + 1);
  localparam int WC_W = $clog2(SEARCH_WORDS + 1);
  localparam int SW_W = $clog2(SLIP_WAIT + 1);
  localparam int CC_W = $clog2(LOCK_CNT + 1);
  localparam int WN_W = $clog2(ERR_WINDOW + 1);
  localparam int EC_W = $clog2(ERR_THRESH + 1);

  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYC - 1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(SEARCH_WORDS - 1);
  localparam logic [SW_W-1:0] SW_LAST = SW_W'(SLIP_WAIT - 1);
  localparam logic [CC_W-1:0] CC_LAST = CC_W'(LOCK_CNT - 1);
  localparam logic [WN_W-1:0] WN_LAST = WN_W'(ERR_WINDOW - 1);
  localparam logic [EC_W-1:0] EC_LAST = EC_W'(ERR_THRESH - 1);

  state_t            state_q, state_d;
  logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
  logic [SW_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CC_W-1:0]   comma_cnt_q, comma_cnt_d;
  logic [WN_W-1:0]   win_cnt_q, win_cnt_d;
  logic [EC_W-1:0]   err_cnt_q, err_cnt_d;
  logic [3:0]        slip_cnt_q, slip_cnt_d;
  logic [7:0]        loss_cnt_q, loss_cnt_d;

  logic bitslip_q, bitslip_d;
  logic soft_reset_q, soft_reset_d;
  logic force_disp_q, force_disp_d;
  logic disparity_q, disparity_d;
  logic locked_q, locked_d;

  logic good_comma, bad_word;

  assign good_comma = i_word_valid & i_Kout & (i_Dout == COMMA) & ~i_DErr;
  assign bad_word   = i_word_valid & (i_DErr | i_DpErr);

  // State and counter registers
  always_ff @(posedge i_Clk or negedge i_ARst_L) begin
    if (!i_ARst_L) begin
      state_q      <= ST_RST_DEC;
      rst_cnt_q    <= '0;
      word_cnt_q   <= '0;
      wait_cnt_q   <= '0;
      comma_cnt_q  <= '0;
      win_cnt_q    <= '0;
      err_cnt_q    <= '0;
      slip_cnt_q   <= '0;
      loss_cnt_q   <= '0;
      bitslip_q    <= 1'b0;
      soft_reset_q <= 1'b1;
      force_disp_q <= 1'b1;
      disparity_q  <= 1'b1;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      word_cnt_q   <= word_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      comma_cnt_q  <= comma_cnt_d;
      win_cnt_q    <= win_cnt_d;
      err_cnt_q    <= err_cnt_d;
      slip_cnt_q   <= slip_cnt_d;
      loss_cnt_q   <= loss_cnt_d;
      bitslip_q    <= bitslip_d;
      soft_reset_q <= soft_reset_d;
      force_disp_q <= force_disp_d;
      disparity_q  <= disparity_d;
      locked_q     <= locked_d;
    end
  end

  // Next state and counter updates
  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    word_cnt_d  = word_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    comma_cnt_d = comma_cnt_q;
    win_cnt_d   = win_cnt_q;
    err_cnt_d   = err_cnt_q;
    slip_cnt_d  = slip_cnt_q;
    loss_cnt_d  = loss_cnt_q;
    case (state_q)
      ST_RST_DEC: begin
        // cycle timer, runs regardless of word valid
        if (rst_cnt_q == RC_LAST) begin
          state_d    = ST_SEARCH;
          rst_cnt_d  = '0;
          word_cnt_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + RC_W'(1);
        end
      end
      ST_SEARCH: begin
        if (i_word_valid) begin
          if (good_comma) begin
            state_d     = ST_CONFIRM;
            comma_cnt_d = CC_W'(1);
            word_cnt_d  = '0;
          end else if (word_cnt_q == WC_LAST) begin
            state_d    = ST_SLIP;
            wait_cnt_d = '0;
            word_cnt_d = '0;
            slip_cnt_d = (slip_cnt_q == 4'd9) ? 4'd0 : slip_cnt_q + 4'd1;
          end else begin
            word_cnt_d = word_cnt_q + WC_W'(1);
          end
        end
      end
      ST_SLIP: begin
        // hold-off while the deserializer settles; inputs are ignored
        if (wait_cnt_q == SW_LAST) begin
          state_d    = ST_SEARCH;
          wait_cnt_d = '0;
          word_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + SW_W'(1);
        end
      end
      ST_CONFIRM: begin
        if (i_word_valid) begin
          if (bad_word) begin
            // errors win over a comma in the same word; no slip, just re-search
            state_d     = ST_SEARCH;
            comma_cnt_d = '0;
            word_cnt_d  = '0;
          end else if (good_comma) begin
            comma_cnt_d = comma_cnt_q + CC_W'(1);
            word_cnt_d  = '0;
            if (comma_cnt_q == CC_LAST) begin
              state_d    = ST_LOCKED;
              win_cnt_d  = '0;
              err_cnt_d  = '0;
              slip_cnt_d = '0;
            end
          end else if (word_cnt_q == WC_LAST) begin
            state_d     = ST_SEARCH;
            comma_cnt_d = '0;
            word_cnt_d  = '0;
          end else begin
            word_cnt_d = word_cnt_q + WC_W'(1);
          end
        end
      end
      ST_LOCKED: begin
        if (i_word_valid) begin
          if (bad_word && (err_cnt_q == EC_LAST)) begin
            state_d   = ST_RST_DEC;
            rst_cnt_d = '0;
            if (loss_cnt_q != 8'hFF) loss_cnt_d = loss_cnt_q + 8'd1;
          end else if (win_cnt_q == WN_LAST) begin
            // last word of the window: its error was already judged above
            win_cnt_d = '0;
            err_cnt_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + WN_W'(1);
            if (bad_word) err_cnt_d = err_cnt_q + EC_W'(1);
          end
        end
      end
      default: state_d = ST_RST_DEC;
    endcase
  end

  // Registered outputs follow the state being entered
  always_comb begin
    bitslip_d    = (state_q == ST_SEARCH) && (state_d == ST_SLIP);
    soft_reset_d = (state_d == ST_RST_DEC);
    force_disp_d = !((state_d == ST_CONFIRM) || (state_d == ST_LOCKED));
    disparity_d  = 1'b1;
    locked_d     = (state_d == ST_LOCKED);
  end

  assign o_bitslip         = bitslip_q;
  assign o_dec_soft_reset  = soft_reset_q;
  assign o_force_disparity = force_disp_q;
  assign o_disparity       = disparity_q;
  assign o_locked          = locked_q;
  assign o_state           = state_q;
  assign o_slip_count      = slip_cnt_q;
  assign o_lock_loss_cnt   = loss_cnt_q;

endmodule

// File: tb/tb_tdc_link_align_ctrl.sv
// Bench for tdc_link_align_ctrl: directed scenarios plus a randomized
// channel (misalignment responding to bitslip, random errors) checked
// every cycle against a word-level model of the link controller.
module tb_tdc_link_align_ctrl;

  localparam int SEARCH_WORDS = 20;
  localparam int SLIP_WAIT    = 16;
  localparam int LOCK_CNT     = 8;
  localparam int ERR_WINDOW   = 64;
  localparam int ERR_THRESH   = 4;
  localparam int RST_CYC      = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wv;
  logic [7:0] dout;
  logic       kout, derr, dperr;
  logic       o_bitslip, o_dec_soft_reset, o_force_disparity, o_disparity, o_locked;
  logic [2:0] o_state;
  logic [3:0] o_slip_count;
  logic [7:0] o_lock_loss_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;
  int ncyc = 0;

  tdc_link_align_ctrl dut (
    .i_Clk(clk), .i_ARst_L(rst_n), .i_word_valid(wv), .i_Dout(dout),
    .i_Kout(kout), .i_DErr(derr), .i_DpErr(dperr),
    .o_bitslip(o_bitslip), .o_dec_soft_reset(o_dec_soft_reset),
    .o_force_disparity(o_force_disparity), .o_disparity(o_disparity),
    .o_locked(o_locked), .o_state(o_state), .o_slip_count(o_slip_count),
    .o_lock_loss_cnt(o_lock_loss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase of the link: 0 reset-decoder, 1 hunting, 2 slip hold-off,
  // 3 confirming, 4 locked.
  int m_ph, m_timer, m_nocomma, m_commas, m_winpos, m_errs, m_slips, m_losses;
  bit m_pulse;

  task automatic model_reset();
    m_ph = 0; m_timer = 0; m_nocomma = 0; m_commas = 0;
    m_winpos = 0; m_errs = 0; m_slips = 0; m_losses = 0; m_pulse = 0;
  endtask

  task automatic model_step();
    bit gc, bw;
    gc = wv && kout && (dout == 8'hBC) && !derr;
    bw = wv && (derr || dperr);
    m_pulse = 0;
    if (m_ph == 0) begin
      m_timer++;
      if (m_timer == RST_CYC) begin m_ph = 1; m_nocomma = 0; end
    end else if (m_ph == 2) begin
      m_timer++;
      if (m_timer == SLIP_WAIT) begin m_ph = 1; m_nocomma = 0; end
    end else if (wv) begin
      if (m_ph == 1) begin
        if (gc) begin m_ph = 3; m_commas = 1; m_nocomma = 0; end
        else begin
          m_nocomma++;
          if (m_nocomma == SEARCH_WORDS) begin
            m_ph = 2; m_timer = 0; m_pulse = 1; m_slips = (m_slips + 1) % 10;
          end
        end
      end else if (m_ph == 3) begin
        if (bw) begin m_ph = 1; m_commas = 0; m_nocomma = 0; end
        else if (gc) begin
          m_commas++; m_nocomma = 0;
          if (m_commas == LOCK_CNT) begin
            m_ph = 4; m_winpos = 0; m_errs = 0; m_slips = 0;
          end
        end else begin
          m_nocomma++;
          if (m_nocomma == SEARCH_WORDS) begin m_ph = 1; m_commas = 0; m_nocomma = 0; end
        end
      end else begin
        m_errs += int'(bw);
        if (m_errs >= ERR_THRESH) begin
          m_ph = 0; m_timer = 0;
          m_losses = (m_losses < 255) ? m_losses + 1 : 255;
        end else begin
          m_winpos = (m_winpos + 1) % ERR_WINDOW;
          if (m_winpos == 0) m_errs = 0;
        end
      end
    end
  endtask

  // single compare process, every cycle
  always @(negedge clk) begin
    if (chk_en) begin
      chk("state",      int'(o_state),           m_ph);
      chk("locked",     int'(o_locked),          int'(m_ph == 4));
      chk("soft_reset", int'(o_dec_soft_reset),  int'(m_ph == 0));
      chk("force_disp", int'(o_force_disparity), int'(m_ph < 3));
      chk("disparity",  int'(o_disparity),       1);
      chk("bitslip",    int'(o_bitslip),         int'(m_pulse));
      chk("slip_count", int'(o_slip_count),      m_slips);
      chk("loss_cnt",   int'(o_lock_loss_cnt),   m_losses);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input bit v, input logic [7:0] d, input bit k, input bit de, input bit dpe);
    wv = v; dout = d; kout = k; derr = de; dperr = dpe;
    @(posedge clk);
    if (!rst_n) model_reset(); else model_step();
    ncyc++;
    #1;
  endtask

  task automatic comma();
    cyc(1, 8'hBC, 1, 0, 0);
  endtask

  task automatic data();
    cyc(1, 8'($urandom_range(0, 255)), 0, 0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 0; model_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
  endtask

  task automatic relock(input string name);
    for (int i = 0; i < 60 && !o_locked; i++) comma();
    chk(name, int'(o_locked), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int mis, pulses, last_pulse;
    bit found;
    rst_n = 0; wv = 0; dout = 0; kout = 0; derr = 0; dperr = 0;
    model_reset();
    chk_en = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", int'(o_state), 0);
    chk("rst_soft", int'(o_dec_soft_reset), 1);
    chk("rst_force", int'(o_force_disparity), 1);
    chk("rst_disp", int'(o_disparity), 1);
    chk("rst_bitslip", int'(o_bitslip), 0);
    #2 rst_n = 1;

    // 1: aligned commas after reset release
    comma();
    chk("p1_soft_c1", int'(o_dec_soft_reset), 1);
    comma();
    chk("p1_soft_c2", int'(o_dec_soft_reset), 0);
    chk("p1_search", int'(o_state), 1);
    repeat (7) comma();
    chk("p1_confirm7", int'(o_state), 3);
    chk("p1_fd0", int'(o_force_disparity), 0);
    chk("p1_unlocked7", int'(o_locked), 0);
    comma();
    chk("p1_locked", int'(o_locked), 1);
    chk("p1_state4", int'(o_state), 4);
    chk("p1_slip0", int'(o_slip_count), 0);

    // 2: misaligned by 3, three slips needed
    do_reset();
    mis = 3; pulses = 0; last_pulse = 0;
    for (int i = 0; i < 2000 && !o_locked; i++) begin
      if (mis > 0) data(); else comma();
      if (o_bitslip) begin
        pulses++;
        if (pulses > 1) chk("p2_slip_period", ncyc - last_pulse, SEARCH_WORDS + SLIP_WAIT);
        if (pulses == 3) chk("p2_slip_count3", int'(o_slip_count), 3);
        last_pulse = ncyc;
        if (mis > 0) mis--;
      end
    end
    chk("p2_locked", int'(o_locked), 1);
    chk("p2_pulses", pulses, 3);
    chk("p2_slip_clr", int'(o_slip_count), 0);

    // 3: error during CONFIRM after 5 commas
    do_reset();
    data(); data();
    repeat (5) comma();
    chk("p3_confirm", int'(o_state), 3);
    cyc(1, 8'h55, 0, 1, 0);
    chk("p3_back_search", int'(o_state), 1);
    chk("p3_no_slip", int'(o_bitslip), 0);
    repeat (7) comma();
    chk("p3_not_yet", int'(o_locked), 0);
    comma();
    chk("p3_relocked", int'(o_locked), 1);

    // 4: 3 errors in a window hold; 4 in the next window lose lock
    for (int i = 0; i < 74; i++) begin
      if (i == 10 || i == 20 || i == 30 || (i >= 70 && i <= 73))
        cyc(1, 8'h3C, 0, i[0], !i[0]);
      else data();
      if (i == 63) chk("p4_hold3", int'(o_locked), 1);
    end
    chk("p4_lost", int'(o_locked), 0);
    chk("p4_state0", int'(o_state), 0);
    chk("p4_loss1", int'(o_lock_loss_cnt), 1);
    relock("p4_relock");

    // 5: errors straddling the window boundary, then last-word error
    for (int i = 0; i < 192; i++) begin
      if ((i >= 61 && i <= 66) || (i >= 128 && i <= 130) || i == 191)
        cyc(1, 8'h77, 0, 1, 0);
      else data();
      if (i == 127) chk("p5_straddle_hold", int'(o_locked), 1);
      if (i == 190) chk("p5_pre_last", int'(o_locked), 1);
    end
    chk("p5_last_word_err", int'(o_locked), 0);
    chk("p5_loss2", int'(o_lock_loss_cnt), 2);

    // 6: async reset while the bitslip pulse is high
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      data();
      found = o_bitslip;
    end
    chk("p6_pulse_seen", int'(found), 1);
    #2 rst_n = 0; model_reset();
    #1;
    chk("p6_bitslip", int'(o_bitslip), 0);
    chk("p6_state", int'(o_state), 0);
    chk("p6_soft", int'(o_dec_soft_reset), 1);
    chk("p6_force", int'(o_force_disparity), 1);
    chk("p6_locked", int'(o_locked), 0);
    chk("p6_slips", int'(o_slip_count), 0);
    chk("p6_loss", int'(o_lock_loss_cnt), 0);
    @(posedge clk); #3 rst_n = 1;

    // 7: randomized channel
    mis = $urandom_range(0, 9);
    for (int i = 0; i < 8000; i++) begin
      bit v, k, de, dpe;
      logic [7:0] d;
      if (i % 2000 == 1999) begin do_reset(); mis = $urandom_range(0, 9); end
      v = ($urandom_range(0, 3) != 0);
      de = ($urandom_range(0, 63) == 0);
      dpe = ($urandom_range(0, 63) == 0);
      d = 8'($urandom_range(0, 255));
      k = 0;
      if (mis == 0) begin
        if ($urandom_range(0, 2) == 0) begin d = 8'hBC; k = 1; end
        else if ($urandom_range(0, 7) == 0) begin d = 8'h1C; k = 1; end
      end
      cyc(v, d, k, de, dpe);
      if (o_bitslip) mis = (mis == 0) ? 9 : mis - 1;
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
